// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: grants the SDRAM command engine to refresh, read or write, one transaction at a time.
// Grant and cmd_valid rise one cycle after idle sampling; the command is held until cmd_ready. Define SDRAM_ARB_STAT_EN for per-type counters.

module sdram_req_arbiter #(
   parameter int ADDR_W       = 24,
   parameter int REF_INTERVAL = 1039,
   parameter int REF_MAX_PEND = 7
) (
   input  logic              sdram_clk,
   input  logic              rst_n,
   input  logic              init_done,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [1:0]        cmd_type,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_done,
   output logic              ref_overflow
`ifdef SDRAM_ARB_STAT_EN
   ,
   output logic [15:0]       stat_wr_cnt,
   output logic [15:0]       stat_rd_cnt,
   output logic [15:0]       stat_ref_cnt
`endif
);

   localparam logic [1:0] CMD_NOP     = 2'd0;
   localparam logic [1:0] CMD_WRITE   = 2'd1;
   localparam logic [1:0] CMD_READ    = 2'd2;
   localparam logic [1:0] CMD_REFRESH = 2'd3;

   localparam int TMR_W  = $clog2(REF_INTERVAL + 1);
   localparam int PEND_W = $clog2(REF_MAX_PEND + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REF_INTERVAL - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(REF_MAX_PEND);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_BUSY} state_t;

   state_t            state;
   logic [TMR_W-1:0]  ref_tmr;
   logic [PEND_W-1:0] ref_pend;
   logic              last_rd;
   logic              ref_wrap;
   logic              cmd_hs;
   logic              ref_taken;
   logic              pick_ref;
   logic              pick_rd;
   logic              pick_wr;

   assign ref_wrap  = (state != S_INIT) && (ref_tmr == TMR_LAST);
   assign cmd_hs    = (state == S_ISSUE) && cmd_valid && cmd_ready;
   assign ref_taken = cmd_hs && (cmd_type == CMD_REFRESH);

   // Refresh always wins; a read/write tie goes to whoever did not win last time.
   assign pick_ref = (ref_pend != '0);
   assign pick_rd  = !pick_ref && rd_req && (!wr_req || !last_rd);
   assign pick_wr  = !pick_ref && wr_req && !pick_rd;

   always_ff @(posedge sdram_clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_tmr <= '0;
      end else if (state == S_INIT || ref_wrap) begin
         ref_tmr <= '0;
      end else begin
         ref_tmr <= ref_tmr + TMR_W'(1);
      end
   end

   // A wrap that coincides with a refresh handshake leaves the pending count as is.
   always_ff @(posedge sdram_clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_pend     <= '0;
         ref_overflow <= 1'b0;
      end else begin
         case ({ref_wrap, ref_taken})
            2'b10: begin
               if (ref_pend == PEND_MAX) begin
                  ref_overflow <= 1'b1;
               end else begin
                  ref_pend <= ref_pend + PEND_W'(1);
               end
            end
            2'b01:   ref_pend <= ref_pend - PEND_W'(1);
            default: ref_pend <= ref_pend;
         endcase
      end
   end

   always_ff @(posedge sdram_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         wr_gnt    <= 1'b0;
         rd_gnt    <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_type  <= CMD_NOP;
         cmd_addr  <= '0;
         last_rd   <= 1'b1;
      end else begin
         case (state)
            S_INIT: begin
               if (init_done) begin
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (pick_ref) begin
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_REFRESH;
                  cmd_addr  <= '0;
                  state     <= S_ISSUE;
               end else if (pick_rd) begin
                  rd_gnt    <= 1'b1;
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_READ;
                  cmd_addr  <= rd_addr;
                  state     <= S_ISSUE;
               end else if (pick_wr) begin
                  wr_gnt    <= 1'b1;
                  cmd_valid <= 1'b1;
                  cmd_type  <= CMD_WRITE;
                  cmd_addr  <= wr_addr;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cmd_done) begin
                  if (cmd_type == CMD_WRITE) begin
                     last_rd <= 1'b0;
                  end else if (cmd_type == CMD_READ) begin
                     last_rd <= 1'b1;
                  end
                  wr_gnt   <= 1'b0;
                  rd_gnt   <= 1'b0;
                  cmd_type <= CMD_NOP;
                  cmd_addr <= '0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

`ifdef SDRAM_ARB_STAT_EN
   always_ff @(posedge sdram_clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_wr_cnt  <= '0;
         stat_rd_cnt  <= '0;
         stat_ref_cnt <= '0;
      end else if (cmd_hs) begin
         case (cmd_type)
            CMD_WRITE:   stat_wr_cnt  <= stat_wr_cnt + 16'd1;
            CMD_READ:    stat_rd_cnt  <= stat_rd_cnt + 16'd1;
            CMD_REFRESH: stat_ref_cnt <= stat_ref_cnt + 16'd1;
            default:     stat_wr_cnt  <= stat_wr_cnt;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: instance a uses the default refresh interval, instance b a 16-cycle one.
// Expected commands are queued by the stimulus and popped by a monitor at every command handshake.

module tb_sdram_req_arbiter;
   localparam int AW = 24;
   localparam logic [1:0] T_WR  = 2'd1;
   localparam logic [1:0] T_RD  = 2'd2;
   localparam logic [1:0] T_REF = 2'd3;

   logic clk = 1'b0;
   always #4 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic          a_rst_n, a_init, a_wr_req, a_rd_req, a_cmd_ready, a_cmd_done;
   logic [AW-1:0] a_wr_addr, a_rd_addr, a_cmd_addr;
   logic          a_wr_gnt, a_rd_gnt, a_cmd_valid, a_ovf;
   logic [1:0]    a_cmd_type;
   logic          b_rst_n, b_init, b_wr_req, b_rd_req, b_cmd_ready, b_cmd_done;
   logic [AW-1:0] b_wr_addr, b_rd_addr, b_cmd_addr;
   logic          b_wr_gnt, b_rd_gnt, b_cmd_valid, b_ovf;
   logic [1:0]    b_cmd_type;
`ifdef SDRAM_ARB_STAT_EN
   logic [15:0]   a_swr, a_srd, a_sref, b_swr, b_srd, b_sref;
`endif

   sdram_req_arbiter #(.ADDR_W(AW)) u_dut_a (
      .sdram_clk(clk), .rst_n(a_rst_n), .init_done(a_init),
      .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_gnt(a_wr_gnt),
      .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_gnt(a_rd_gnt),
      .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_type(a_cmd_type),
      .cmd_addr(a_cmd_addr), .cmd_done(a_cmd_done), .ref_overflow(a_ovf)
`ifdef SDRAM_ARB_STAT_EN
      , .stat_wr_cnt(a_swr), .stat_rd_cnt(a_srd), .stat_ref_cnt(a_sref)
`endif
   );

   sdram_req_arbiter #(.ADDR_W(AW), .REF_INTERVAL(16), .REF_MAX_PEND(7)) u_dut_b (
      .sdram_clk(clk), .rst_n(b_rst_n), .init_done(b_init),
      .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_gnt(b_wr_gnt),
      .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_type(b_cmd_type),
      .cmd_addr(b_cmd_addr), .cmd_done(b_cmd_done), .ref_overflow(b_ovf)
`ifdef SDRAM_ARB_STAT_EN
      , .stat_wr_cnt(b_swr), .stat_rd_cnt(b_srd), .stat_ref_cnt(b_sref)
`endif
   );

   typedef struct packed {
      logic [1:0]    typ;
      logic [AW-1:0] addr;
      logic          wg;
      logic          rg;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   function automatic exp_t mk(input logic [1:0] t, input logic [AW-1:0] a,
                               input logic w, input logic r);
      exp_t e;
      e.typ  = t;
      e.addr = a;
      e.wg   = w;
      e.rg   = r;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (a_cmd_valid && a_cmd_ready) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_cmd actual type=%0d addr=%h required=no command", a_cmd_type, a_cmd_addr);
         end else begin
            ea = qa.pop_front();
            chk("a_cmd", 32'({a_cmd_type, a_cmd_addr, a_wr_gnt, a_rd_gnt}), 32'(ea));
         end
      end
      if (b_cmd_valid && b_cmd_ready) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_cmd actual type=%0d addr=%h required=no command", b_cmd_type, b_cmd_addr);
         end else begin
            eb = qb.pop_front();
            chk("b_cmd", 32'({b_cmd_type, b_cmd_addr, b_wr_gnt, b_rd_gnt}), 32'(eb));
         end
      end
      chk("gnt_onehot", 32'({a_wr_gnt & a_rd_gnt, b_wr_gnt & b_rd_gnt}), 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wait_valid(output int t);
      int n = 0;
      while (!a_cmd_valid && n < 100) begin
         tick();
         n++;
      end
      if (!a_cmd_valid) begin
         checks++;
         failures++;
         $display("FAIL a_wait_valid timeout actual=cmd_valid 0 required=1");
      end
      t = cyc;
   endtask

   task automatic b_wait_valid(output int t);
      int n = 0;
      while (!b_cmd_valid && n < 100) begin
         tick();
         n++;
      end
      if (!b_cmd_valid) begin
         checks++;
         failures++;
         $display("FAIL b_wait_valid timeout actual=cmd_valid 0 required=1");
      end
      t = cyc;
   endtask

   task automatic a_serve(input int dly, input bit drop);
      int t;
      a_wait_valid(t);
      if (drop) begin
         a_wr_req = 1'b0;
         a_rd_req = 1'b0;
      end
      tick();
      repeat (dly) tick();
      a_cmd_done = 1'b1;
      tick();
      a_cmd_done = 1'b0;
   endtask

   task automatic b_serve(input int dly, output int t);
      b_wait_valid(t);
      tick();
      repeat (dly) tick();
      b_cmd_done = 1'b1;
      tick();
      b_cmd_done = 1'b0;
   endtask

   initial begin
      int t1, t2, t3, t4;
      a_rst_n = 1'b0; a_init = 1'b0; a_wr_req = 1'b0; a_rd_req = 1'b0;
      a_cmd_ready = 1'b0; a_cmd_done = 1'b0; a_wr_addr = '0; a_rd_addr = '0;
      b_rst_n = 1'b0; b_init = 1'b0; b_wr_req = 1'b0; b_rd_req = 1'b0;
      b_cmd_ready = 1'b0; b_cmd_done = 1'b0; b_wr_addr = '0; b_rd_addr = '0;
      repeat (3) tick();
      chk("reset_outputs_a", 32'({a_wr_gnt, a_rd_gnt, a_cmd_valid, a_cmd_type, a_cmd_addr, a_ovf}), 32'd0);
      chk("reset_outputs_b", 32'({b_wr_gnt, b_rd_gnt, b_cmd_valid, b_cmd_type, b_cmd_addr, b_ovf}), 32'd0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;

      // No grant while init is incomplete.
      a_wr_req  = 1'b1;
      a_wr_addr = 24'h000100;
      repeat (50) begin
         tick();
         chk("no_gnt_before_init", 32'({a_wr_gnt, a_cmd_valid}), 32'd0);
      end

      // Single write: grant one cycle after entering idle, held to cmd_done.
      a_cmd_ready = 1'b1;
      qa.push_back(mk(T_WR, 24'h000100, 1'b1, 1'b0));
      a_init = 1'b1;
      tick();
      chk("wr_not_yet_granted", 32'(a_wr_gnt), 32'd0);
      tick();
      chk("wr_gnt", 32'({a_wr_gnt, a_rd_gnt, a_cmd_valid}), 32'b101);
      chk("wr_cmd_type", 32'(a_cmd_type), 32'(T_WR));
      chk("wr_cmd_addr", 32'(a_cmd_addr), 32'h000100);
      tick();
      a_wr_req = 1'b0;
      repeat (3) tick();
      chk("wr_busy_hold", 32'({a_wr_gnt, a_cmd_valid}), 32'b10);
      a_cmd_done = 1'b1;
      tick();
      a_cmd_done = 1'b0;
      chk("wr_release", 32'({a_wr_gnt, a_cmd_type, a_cmd_addr}), 32'd0);

      // Simultaneous read and write alternate, starting with write.
      a_rst_n = 1'b0;
      tick();
      a_wr_req = 1'b1; a_rd_req = 1'b1;
      a_wr_addr = 24'h000200; a_rd_addr = 24'h000300;
      qa.push_back(mk(T_WR, 24'h000200, 1'b1, 1'b0));
      qa.push_back(mk(T_RD, 24'h000300, 1'b0, 1'b1));
      qa.push_back(mk(T_WR, 24'h000200, 1'b1, 1'b0));
      qa.push_back(mk(T_RD, 24'h000300, 1'b0, 1'b1));
      a_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) a_init = 1'b0;
         a_serve(8, i == 3);
      end
      repeat (5) tick();
      chk("alternate_queue_drained", 32'(qa.size()), 32'd0);
      chk("alternate_idle", 32'({a_wr_gnt, a_rd_gnt, a_cmd_valid}), 32'd0);

      // cmd_done ignored in issue, then async reset while busy.
      a_cmd_ready = 1'b0;
      a_wr_addr = 24'h00F00D;
      qa.push_back(mk(T_WR, 24'h00F00D, 1'b1, 1'b0));
      a_wr_req = 1'b1;
      a_wait_valid(t1);
      a_cmd_done = 1'b1;
      tick();
      a_cmd_done = 1'b0;
      tick();
      chk("issue_hold", 32'({a_cmd_valid, a_wr_gnt, a_cmd_type, a_cmd_addr}), 32'({1'b1, 1'b1, T_WR, 24'h00F00D}));
      a_cmd_ready = 1'b1;
      tick();
      chk("busy_after_hs", 32'({a_cmd_valid, a_wr_gnt}), 32'b01);
      #2;
      a_rst_n = 1'b0;
      a_init  = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({a_wr_gnt, a_rd_gnt, a_cmd_valid, a_cmd_type, a_cmd_addr}), 32'd0);
      tick();
      tick();
      a_rst_n = 1'b1;
      repeat (10) tick();
      chk("no_gnt_after_reset", 32'({a_wr_gnt, a_cmd_valid}), 32'd0);
      qa.push_back(mk(T_WR, 24'h00F00D, 1'b1, 1'b0));
      a_init = 1'b1;
      a_serve(3, 1'b1);
      tick();
      chk("after_reset_idle", 32'({a_wr_gnt, a_cmd_valid, 6'(qa.size())}), 32'd0);

      // Refresh every 16 cycles; a pending refresh beats a waiting write.
      b_cmd_ready = 1'b1;
      b_init = 1'b1;
      repeat (4) qb.push_back(mk(T_REF, 24'h0, 1'b0, 1'b0));
      qb.push_back(mk(T_WR, 24'h00ABCD, 1'b1, 1'b0));
      b_serve(2, t1);
      b_serve(2, t2);
      b_wait_valid(t3);
      tick();
      b_wr_req = 1'b1;
      b_wr_addr = 24'h00ABCD;
      repeat (20) tick();
      b_cmd_done = 1'b1;
      tick();
      b_cmd_done = 1'b0;
      chk("ref_period_1", 32'(t2 - t1), 32'd16);
      chk("ref_period_2", 32'(t3 - t2), 32'd16);
      b_serve(2, t4);
      b_wait_valid(t4);
      tick();
      b_cmd_ready = 1'b0;
      b_wr_req = 1'b0;
      b_cmd_done = 1'b1;
      tick();
      b_cmd_done = 1'b0;
      chk("ref_then_wr_drained", 32'(qb.size()), 32'd0);

      // Controller stalled: pending refreshes saturate and overflow sticks.
      b_rst_n = 1'b0;
      tick();
      tick();
      b_rst_n = 1'b1;
      chk("ovf_clear_after_reset", 32'(b_ovf), 32'd0);
      repeat (120) tick();
      chk("ovf_not_yet", 32'(b_ovf), 32'd0);
      repeat (80) tick();
      chk("ovf_set", 32'({b_ovf, b_cmd_valid, b_cmd_type}), 32'({1'b1, 1'b1, T_REF}));
      repeat (20) tick();
      chk("ovf_sticky", 32'(b_ovf), 32'd1);
      b_rst_n = 1'b0;
      #1;
      chk("ovf_reset", 32'(b_ovf), 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
